// File: rtl/keynsham_irq_ctrl.sv
// ----------------------------------------------------------------------------
// keynsham_irq_ctrl
//
// Small interrupt controller sitting on the peripheral bus. It collects up to
// NUM_IRQS sources, each configurable as edge or level triggered. It presents
// the lowest-numbered pending and enabled source to the CPU through a
// claim / end-of-interrupt handshake. Nesting is not supported: while a claimed
// interrupt is in service, irq_out stays low and new requests only accumulate
// in PENDING.
//
// Register map (reg_sel):
//   0 RAW     RO  current irq_in
//   1 PENDING RO  pending bits
//   2 ENABLE  RW  per-source enable
//   3 TYPE    RW  1 = edge, 0 = level (changing a bit clears its pending bit)
//   4 CLAIM   RO  selected id in ACTIVE (moves to SERVICE), else all ones
//   5 EOI     WO  write the claimed id to return to IDLE
//   6 SWSET   WO  set pending for edge sources
//   7 -           reserved, access flags bus_error
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bus_access   bus cycle valid
//   irq_cs       controller chip select
//   reg_sel      register index
//   bus_wr_val   write data (only low NUM_IRQS bits are stored)
//   bus_wr_en    1 = write, 0 = read
//   bus_bytesel  byte enables, ignored (all writes are full-word)
//   irq_in       interrupt sources, synchronous to clk
//   bus_error    registered error for reserved-register accesses
//   bus_ack      registered acknowledge, one cycle after the access
//   bus_data     combinational read data
//   irq_out      interrupt request to the CPU, high only in ACTIVE
// ----------------------------------------------------------------------------
module keynsham_irq_ctrl #(
    parameter int NUM_IRQS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bus_access,
    input  logic                irq_cs,
    input  logic [2:0]          reg_sel,
    input  logic [31:0]         bus_wr_val,
    input  logic                bus_wr_en,
    input  logic [3:0]          bus_bytesel,
    input  logic [NUM_IRQS-1:0] irq_in,
    output logic                bus_error,
    output logic                bus_ack,
    output logic [31:0]         bus_data,
    output logic                irq_out
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACTIVE  = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    localparam logic [2:0] R_RAW     = 3'd0;
    localparam logic [2:0] R_PENDING = 3'd1;
    localparam logic [2:0] R_ENABLE  = 3'd2;
    localparam logic [2:0] R_TYPE    = 3'd3;
    localparam logic [2:0] R_CLAIM   = 3'd4;
    localparam logic [2:0] R_EOI     = 3'd5;
    localparam logic [2:0] R_SWSET   = 3'd6;
    localparam logic [2:0] R_RSVD    = 3'd7;

    logic [NUM_IRQS-1:0] pend_q, pend_d;
    logic [NUM_IRQS-1:0] en_q, en_d;
    logic [NUM_IRQS-1:0] type_q, type_d;
    logic [NUM_IRQS-1:0] prev_q;
    logic [1:0]          state_q, state_d;
    logic [3:0]          claim_q, claim_d;
    logic                ack_q, err_q;

    logic                access, rd_acc, wr_acc;
    logic                cand_vld;
    logic [3:0]          cand_id;
    logic                claim_go;
    logic                eoi_go;
    logic [NUM_IRQS-1:0] wr_bits;
    logic [NUM_IRQS-1:0] type_chg, rise, sw_set, claim_clr, edge_next;

    // Byte enables and the upper write-data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus_bytesel, bus_wr_val[31:NUM_IRQS]};

    assign access  = bus_access && irq_cs;
    assign rd_acc  = access && !bus_wr_en;
    assign wr_acc  = access && bus_wr_en;
    assign wr_bits = bus_wr_val[NUM_IRQS-1:0];

    // Lowest index wins: scan from the top so the last hit is the smallest.
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = 4'd0;
        for (int i = NUM_IRQS - 1; i >= 0; i--) begin
            if (pend_q[i] && en_q[i]) begin
                cand_vld = 1'b1;
                cand_id  = 4'(i);
            end
        end
    end

    // A claim only counts when there is still a candidate to hand out.
    assign claim_go = rd_acc && (reg_sel == R_CLAIM) && (state_q == ACTIVE) && cand_vld;
    assign eoi_go   = wr_acc && (reg_sel == R_EOI) && (state_q == SERVICE)
                      && (bus_wr_val[3:0] == claim_q);

    always_comb begin
        type_chg  = (wr_acc && reg_sel == R_TYPE) ? (wr_bits ^ type_q) : '0;
        rise      = irq_in & ~prev_q;
        sw_set    = (wr_acc && reg_sel == R_SWSET) ? wr_bits : '0;
        for (int i = 0; i < NUM_IRQS; i++) begin
            claim_clr[i] = claim_go && (cand_id == 4'(i));
        end
        // Set terms are ORed after the claim clear so a coincident edge survives.
        edge_next = (pend_q & ~claim_clr) | rise | sw_set;
        pend_d    = ((type_q & edge_next) | (~type_q & irq_in)) & ~type_chg;
        en_d      = (wr_acc && reg_sel == R_ENABLE) ? wr_bits : en_q;
        type_d    = (wr_acc && reg_sel == R_TYPE)   ? wr_bits : type_q;
    end

    always_comb begin
        state_d = state_q;
        claim_d = claim_q;
        case (state_q)
            IDLE: begin
                if (cand_vld) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (claim_go) begin
                    state_d = SERVICE;
                    claim_d = cand_id;
                end else if (!cand_vld) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi_go) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            en_q    <= '0;
            type_q  <= '0;
            prev_q  <= '0;
            state_q <= IDLE;
            claim_q <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            en_q    <= en_d;
            type_q  <= type_d;
            prev_q  <= irq_in;
            state_q <= state_d;
            claim_q <= claim_d;
            ack_q   <= access;
            err_q   <= access && (reg_sel == R_RSVD);
        end
    end

    always_comb begin
        bus_data = 32'd0;
        case (reg_sel)
            R_RAW:     bus_data = 32'(irq_in);
            R_PENDING: bus_data = 32'(pend_q);
            R_ENABLE:  bus_data = 32'(en_q);
            R_TYPE:    bus_data = 32'(type_q);
            R_CLAIM:   bus_data = (state_q == ACTIVE && cand_vld) ? 32'(cand_id) : 32'hffff_ffff;
            default:   bus_data = 32'd0;
        endcase
    end

    assign bus_ack   = ack_q;
    assign bus_error = err_q;
    assign irq_out   = (state_q == ACTIVE);

endmodule

// File: tb/tb_keynsham_irq_ctrl.sv
module tb_keynsham_irq_ctrl;

    localparam int N = 8;
    localparam int S_IDLE = 0;
    localparam int S_ACT  = 1;
    localparam int S_SVC  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          bus_access;
    logic          irq_cs;
    logic [2:0]    reg_sel;
    logic [31:0]   bus_wr_val;
    logic          bus_wr_en;
    logic [3:0]    bus_bytesel;
    logic [N-1:0]  irq_in;
    logic          bus_error;
    logic          bus_ack;
    logic [31:0]   bus_data;
    logic          irq_out;

    int checks = 0;
    int errors = 0;

    // Behavioural reference model state
    int           m_state;
    int           m_claim;
    logic [N-1:0] m_pend, m_en, m_type, m_prev;
    logic         m_ack, m_err;

    keynsham_irq_ctrl #(.NUM_IRQS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_access (bus_access),
        .irq_cs     (irq_cs),
        .reg_sel    (reg_sel),
        .bus_wr_val (bus_wr_val),
        .bus_wr_en  (bus_wr_en),
        .bus_bytesel(bus_bytesel),
        .irq_in     (irq_in),
        .bus_error  (bus_error),
        .bus_ack    (bus_ack),
        .bus_data   (bus_data),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    function automatic int m_sel();
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_en[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] sel);
        case (sel)
            3'd0: return {24'd0, irq_in};
            3'd1: return {24'd0, m_pend};
            3'd2: return {24'd0, m_en};
            3'd3: return {24'd0, m_type};
            3'd4: return (m_state == S_ACT && m_sel() >= 0) ? m_sel() : 32'hffff_ffff;
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock: model the effect of the present inputs, then let the DUT clock.
    task automatic tick();
        int sel, ns, nc;
        bit acc, rd, wr, claim;
        logic [N-1:0] np, ne, nt;
        acc   = bus_access && irq_cs;
        rd    = acc && !bus_wr_en;
        wr    = acc && bus_wr_en;
        sel   = m_sel();
        claim = rd && reg_sel == 3'd4 && m_state == S_ACT && sel >= 0;
        ne = (wr && reg_sel == 3'd2) ? bus_wr_val[N-1:0] : m_en;
        nt = (wr && reg_sel == 3'd3) ? bus_wr_val[N-1:0] : m_type;
        for (int i = 0; i < N; i++) begin
            if (nt[i] != m_type[i])                  np[i] = 1'b0;
            else if (!m_type[i])                     np[i] = irq_in[i];
            else if ((irq_in[i] && !m_prev[i]) ||
                     (wr && reg_sel == 3'd6 && bus_wr_val[i])) np[i] = 1'b1;
            else if (claim && sel == i)              np[i] = 1'b0;
            else                                     np[i] = m_pend[i];
        end
        ns = m_state;
        nc = m_claim;
        if (m_state == S_IDLE && sel >= 0) ns = S_ACT;
        else if (m_state == S_ACT) begin
            if (claim) begin ns = S_SVC; nc = sel; end
            else if (sel < 0) ns = S_IDLE;
        end else if (m_state == S_SVC && wr && reg_sel == 3'd5 && bus_wr_val[3:0] == m_claim[3:0])
            ns = S_IDLE;
        @(posedge clk);
        #1;
        if (rst) begin
            m_pend = '0; m_en = '0; m_type = '0; m_prev = '0;
            m_state = S_IDLE; m_claim = 0; m_ack = 0; m_err = 0;
        end else begin
            m_pend = np; m_en = ne; m_type = nt; m_prev = irq_in;
            m_state = ns; m_claim = nc;
            m_ack = acc; m_err = acc && reg_sel == 3'd7;
        end
    endtask

    task automatic idle_bus();
        bus_access = 0; irq_cs = 0; bus_wr_en = 0; reg_sel = 3'd0; bus_wr_val = 0; bus_bytesel = 4'hf;
    endtask

    task automatic do_reset();
        idle_bus();
        irq_in = '0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic bus_write(input logic [2:0] sel, input logic [31:0] val);
        bus_access = 1; irq_cs = 1; bus_wr_en = 1; reg_sel = sel; bus_wr_val = val;
        tick();
        idle_bus();
    endtask

    task automatic bus_read(input logic [2:0] sel, output logic [31:0] d);
        bus_access = 1; irq_cs = 1; bus_wr_en = 0; reg_sel = sel;
        #1;
        d = bus_data;
        tick();
        idle_bus();
    endtask

    task automatic peek(input logic [2:0] sel, output logic [31:0] d);
        reg_sel = sel;
        #1;
        d = bus_data;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq_out: got %b expected 0", irq_out); end
        checks++; if (bus_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus_ack); end
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus_error); end
        peek(3'd1, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h expected 0", d); end
        peek(3'd2, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_enable: got %h expected 0", d); end
        peek(3'd4, d);
        checks++; if (d !== 32'hffff_ffff) begin errors++; $display("FAIL reset_claim: got %h expected ffffffff", d); end
    endtask

    task automatic test_edge();
        logic [31:0] d;
        do_reset();
        bus_write(3'd2, 32'h1);
        bus_write(3'd3, 32'h1);
        irq_in = 8'h01; tick(); irq_in = 8'h00;
        peek(3'd1, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL edge_pending: got %h expected 1", d); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL edge_irq_early: got %b expected 0", irq_out); end
        tick();
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL edge_irq_out: got %b expected 1", irq_out); end
        bus_read(3'd4, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL edge_claim: got %h expected 0", d); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL edge_irq_after_claim: got %b expected 0", irq_out); end
        peek(3'd1, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL edge_pending_cleared: got %h expected 0", d); end
        bus_write(3'd5, 32'd0);
        bus_read(3'd4, d);
        checks++; if (d !== 32'hffff_ffff) begin errors++; $display("FAIL edge_idle_claim: got %h expected ffffffff", d); end
    endtask

    task automatic test_level();
        logic [31:0] d;
        do_reset();
        bus_write(3'd2, 32'h6);
        irq_in = 8'h06;
        tick(); tick();
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL level_irq_out: got %b expected 1", irq_out); end
        bus_read(3'd4, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL level_claim1: got %h expected 1", d); end
        bus_write(3'd5, 32'd1);
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL level_after_eoi: got %b expected 0", irq_out); end
        tick();
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL level_reassert: got %b expected 1", irq_out); end
        bus_read(3'd4, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL level_claim2: got %h expected 1", d); end
        irq_in = 8'h00;
        bus_write(3'd5, 32'd1);
    endtask

    task automatic test_eoi_mismatch();
        logic [31:0] d;
        do_reset();
        bus_write(3'd2, 32'h1);
        bus_write(3'd3, 32'h1);
        irq_in = 8'h01; tick(); irq_in = 8'h00; tick();
        bus_read(3'd4, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL mism_claim: got %h expected 0", d); end
        bus_write(3'd5, 32'd3);
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL mism_irq_out: got %b expected 0", irq_out); end
        bus_read(3'd4, d);
        checks++; if (d !== 32'hffff_ffff) begin errors++; $display("FAIL mism_service_claim: got %h expected ffffffff", d); end
        irq_in = 8'h01; tick(); irq_in = 8'h00;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL mism_no_nesting: got %b expected 0", irq_out); end
        bus_write(3'd5, 32'd0);
        tick();
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL mism_accumulated: got %b expected 1", irq_out); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        do_reset();
        bus_write(3'd2, 32'h1);
        bus_write(3'd3, 32'h1);
        irq_in = 8'h01; tick(); irq_in = 8'h00; tick();
        irq_in = 8'h01;
        bus_read(3'd4, d);
        irq_in = 8'h00;
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL same_claim: got %h expected 0", d); end
        peek(3'd1, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL same_set_wins: got %h expected 1", d); end
        bus_write(3'd5, 32'd0);
        tick();
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL same_reassert: got %b expected 1", irq_out); end
        bus_read(3'd4, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL same_claim2: got %h expected 0", d); end
    endtask

    task automatic test_error();
        logic [31:0] d;
        logic [7:0]  raw;
        do_reset();
        bus_read(3'd7, d);
        checks++; if (bus_ack !== 1'b1 || bus_error !== 1'b1) begin errors++; $display("FAIL err_rsvd: got ack=%b err=%b expected ack=1 err=1", bus_ack, bus_error); end
        raw = 8'($urandom_range(1, 255));
        irq_in = raw;
        bus_read(3'd0, d);
        checks++; if (d !== {24'd0, raw}) begin errors++; $display("FAIL err_raw_data: got %h expected %h", d, {24'd0, raw}); end
        checks++; if (bus_ack !== 1'b1 || bus_error !== 1'b0) begin errors++; $display("FAIL err_raw_flags: got ack=%b err=%b expected ack=1 err=0", bus_ack, bus_error); end
        irq_in = 8'h00;
        tick();
        checks++; if (bus_ack !== 1'b0) begin errors++; $display("FAIL err_ack_drop: got %b expected 0", bus_ack); end
    endtask

    task automatic test_reset_service();
        logic [31:0] d;
        do_reset();
        bus_write(3'd2, 32'h3);
        irq_in = 8'h02; tick(); tick();
        bus_read(3'd4, d);
        rst = 1; tick(); rst = 0;
        irq_in = 8'h00;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL rstsvc_irq: got %b expected 0", irq_out); end
        peek(3'd1, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstsvc_pending: got %h expected 0", d); end
        peek(3'd2, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rstsvc_enable: got %h expected 0", d); end
        peek(3'd4, d);
        checks++; if (d !== 32'hffff_ffff) begin errors++; $display("FAIL rstsvc_claim: got %h expected ffffffff", d); end
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            bus_access  = ($urandom_range(0, 1) == 1);
            irq_cs      = ($urandom_range(0, 3) != 0);
            bus_wr_en   = ($urandom_range(0, 1) == 1);
            reg_sel     = 3'($urandom_range(0, 7));
            bus_wr_val  = $urandom;
            bus_wr_val[3:0] = 4'($urandom_range(0, 7));
            bus_bytesel = 4'($urandom);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 3) == 0) irq_in[b] = ~irq_in[b];
            #1;
            exp_d = m_rdata(reg_sel);
            checks++; if (bus_data !== exp_d) begin errors++; $display("FAIL rand_data[%0d] sel=%0d: got %h expected %h", n, reg_sel, bus_data, exp_d); end
            tick();
            checks++; if (irq_out !== (m_state == S_ACT)) begin errors++; $display("FAIL rand_irq[%0d]: got %b expected %b", n, irq_out, m_state == S_ACT); end
            checks++; if (bus_ack !== m_ack || bus_error !== m_err) begin errors++; $display("FAIL rand_flags[%0d]: got ack=%b err=%b expected ack=%b err=%b", n, bus_ack, bus_error, m_ack, m_err); end
        end
        rst = 0;
        idle_bus();
    endtask

    initial begin
        m_state = S_IDLE; m_claim = 0;
        m_pend = '0; m_en = '0; m_type = '0; m_prev = '0; m_ack = 0; m_err = 0;
        idle_bus();
        irq_in = '0;
        rst = 1;
        tick();
        test_reset();
        test_edge();
        test_level();
        test_eoi_mismatch();
        test_same_cycle();
        test_error();
        test_reset_service();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keynsham_irq_ctrl.md
KEYNSHAM_IRQ_CTRL -- requirements
Module: keynsham_irq_ctrl

Interface
REQ-001 Parameter NUM_IRQS, default 8, number of interrupt inputs (1..16).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 bus_access  input  1  bus cycle valid.
REQ-005 irq_cs  input  1  controller chip select; access = bus_access && irq_cs.
REQ-006 reg_sel  input  3  register index.
REQ-007 bus_wr_val  input  32  write data.
REQ-008 bus_wr_en  input  1  1 = write, 0 = read.
REQ-009 bus_bytesel  input  4  byte enables; ignored, all writes full-word.
REQ-010 irq_in  input  NUM_IRQS  interrupt sources (e.g. timer), synchronous to clk.
REQ-011 bus_error  output  1  access error, registered.
REQ-012 bus_ack  output  1  access acknowledge, registered.
REQ-013 bus_data  output  32  read data, combinational from reg_sel and state.
REQ-014 irq_out  output  1  interrupt request to CPU, registered.

Function
REQ-015 Register map (reg_sel): 0 RAW (RO, irq_in), 1 PENDING (RO), 2 ENABLE (RW), 3 TYPE (RW, bit=1 edge, 0 level), 4 CLAIM (RO, side effect), 5 EOI (WO), 6 SWSET (WO), 7 reserved.
REQ-016 All registers zero-extended to 32 bits; unused upper bits read 0 and ignore writes.
REQ-017 bus_ack SHALL equal access delayed one cycle; bus_error SHALL equal (access && reg_sel==7) delayed one cycle.
REQ-018 Writes to RO registers and reads of WO registers (data 0) complete with ack, no error, no state change.
REQ-019 Edge source i: pending[i] set on cycle after irq_in[i] 0->1 (previous-sample register); level source i: pending[i] = irq_in[i] registered.
REQ-020 SWSET write sets pending[i] for each set bit i with TYPE[i]=1; bits for level sources ignored.
REQ-021 Selected id = lowest index i with pending[i] && enable[i]; none -> no candidate.
REQ-022 States: IDLE, ACTIVE, SERVICE; irq_out = 1 only in ACTIVE.
REQ-023 IDLE -> ACTIVE next cycle when a candidate exists.
REQ-024 ACTIVE -> IDLE if candidate disappears (disable or level drop) before claim.
REQ-025 CLAIM read in ACTIVE: bus_data = selected id; next cycle state = SERVICE, claimed id latched, edge pending bit of that id cleared.
REQ-026 CLAIM read in IDLE or SERVICE: bus_data = 32'hffffffff, no state change.
REQ-027 EOI write in SERVICE with bus_wr_val[3:0] == claimed id -> IDLE next cycle; mismatched id or other state ignored.
REQ-028 In SERVICE no new irq_out (no nesting); pending bits continue to accumulate.
REQ-029 New edge on same bit in the cycle its pending is cleared by claim: set wins, pending remains 1.
REQ-030 Changing TYPE of a bit clears its pending bit; ENABLE changes take effect on selection next cycle.

Reset
REQ-031 On rst: PENDING, ENABLE, TYPE, edge-history = 0; state IDLE; irq_out, bus_ack, bus_error = 0.
REQ-032 rst in ACTIVE or SERVICE aborts to IDLE; claimed id discarded; no EOI required.

Verification
REQ-033 Write ENABLE=0x01, TYPE=0x01; pulse irq_in[0] 1 cycle -> PENDING=0x01, irq_out=1 two cycles after pulse; CLAIM reads 0 -> irq_out=0, PENDING=0x00; EOI write 0 -> IDLE.
REQ-034 ENABLE=0x06, level irq_in[1] and irq_in[2] held high -> CLAIM returns 1; EOI 1 with inputs held -> irq_out reasserts, CLAIM returns 1 again.
REQ-035 In SERVICE (id 0): EOI write 3 -> state unchanged, irq_out stays 0; CLAIM reads 0xffffffff; EOI 0 -> IDLE.
REQ-036 Edge source 0 enabled, edge on irq_in[0] in same cycle as CLAIM of id 0 -> after EOI, irq_out reasserts, CLAIM returns 0.
REQ-037 Access reg_sel=7 -> bus_ack=1, bus_error=1 one cycle later; reg_sel=0 read -> bus_error=0, bus_data=irq_in.
REQ-038 rst asserted in SERVICE -> next cycle irq_out=0, PENDING=0, ENABLE=0, CLAIM reads 0xffffffff.
